// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART bus controller: the SPART register map,
// the supported baud rates, the controller FSM encoding and the helper that
// turns a clock frequency and a baud select into the divisor register value.
// No ports (package).
// ---------------------------------------------------------------------------
package spart_pkg;

    // SPART register map (ioaddr)
    localparam logic [1:0] IOA_BUF  = 2'b00;  // TX/RX buffer
    localparam logic [1:0] IOA_STAT = 2'b01;  // status
    localparam logic [1:0] IOA_DBL  = 2'b10;  // divisor low byte
    localparam logic [1:0] IOA_DBH  = 2'b11;  // divisor high byte

    // Baud rate selected by br_cfg
    localparam int unsigned BAUD [4] = '{4800, 9600, 19200, 38400};

    // br_cfg_q comes out of reset as 9600 baud; if the pins say otherwise the
    // first IDLE cycle sees the mismatch and reloads the divisor.
    localparam logic [1:0] BR_CFG_RST = 2'b01;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        RX_READ,
        TX_WRITE,
        TX_WAIT
    } state_t;

    // divisor = clk_hz / baud - 1, truncated to 16 bits
    function automatic logic [15:0] baud_div(input int unsigned clk_hz,
                                             input logic [1:0]  sel);
        int unsigned d;
        d = clk_hz / BAUD[sel] - 1;
        return d[15:0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone request is granted outright; when both
// clients request, the client the pointer prefers wins. On advance_i the
// pointer moves to the client that was not granted.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset (pointer -> client 0)
//   req_i      in   [1:0] request per client
//   advance_i  in   grant is being consumed this cycle
//   gnt_o      out  [1:0] one-hot grant (0 when no request)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;  // preferred client under contention

    always_comb begin
        if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
        else                gnt_o = req_i;
    end

    always_comb begin
        ptr_d = ptr_q;
        // after granting client 0 prefer client 1, and vice versa
        if (advance_i && (gnt_o != 2'b00)) ptr_d = gnt_o[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= 1'b0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// ---------------------------------------------------------------------------
// spart_bus_ctrl
// Bus master for one SPART instance. Loads the baud divisor after reset and
// whenever br_cfg changes, drains received bytes when rda is set, and sends
// bytes from two TX clients chosen round-robin, waiting for tbr to fall and
// rise again after every write (with a timeout).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   br_cfg    in  [1:0] baud select 4800/9600/19200/38400
//   tx_req    in  [1:0] per-client level request, held until tx_ack
//   tx_data0/1 in [7:0] client bytes
//   tx_ack    out [1:0] one-hot, high during the write cycle
//   rx_data   out [7:0] last received byte
//   rx_valid  out       1-cycle pulse after a buffer read
//   cfg_done  out       divisor loaded
//   tx_err    out       1-cycle pulse on TX_WAIT timeout
//   iocs/iorw/ioaddr    SPART bus control (Moore-decoded from state)
//   databus   io  [7:0] driven only on writes
//   rda, tbr  in        SPART receive-available / transmit-ready
// ---------------------------------------------------------------------------
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TX_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic [1:0] tx_req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       cfg_done,
    output logic       tx_err,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr
);

    localparam logic [15:0] DIV_TAB [4] = '{
        baud_div(CLK_HZ, 2'd0), baud_div(CLK_HZ, 2'd1),
        baud_div(CLK_HZ, 2'd2), baud_div(CLK_HZ, 2'd3)
    };
    localparam logic [15:0] TO_LAST = 16'(TX_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  br_cfg_q, br_cfg_d;
    logic        cfg_done_q, cfg_done_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_err_q, tx_err_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        seen_low_q, seen_low_d;
    logic [15:0] cnt_q, cnt_d;

    logic [1:0]  gnt;
    logic        adv;
    logic [15:0] div;
    logic        bus_oe;
    logic [7:0]  bus_do;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (tx_req),
        .advance_i(adv),
        .gnt_o    (gnt)
    );

    // Divisor always follows the captured select, never the raw pins
    assign div = DIV_TAB[br_cfg_q];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT_LO;
            br_cfg_q   <= BR_CFG_RST;
            cfg_done_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_err_q   <= 1'b0;
            gnt_q      <= 2'b00;
            seen_low_q <= 1'b0;
            cnt_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            br_cfg_q   <= br_cfg_d;
            cfg_done_q <= cfg_done_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_err_q   <= tx_err_d;
            gnt_q      <= gnt_d;
            seen_low_q <= seen_low_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d    = state_q;
        br_cfg_d   = br_cfg_q;
        cfg_done_d = cfg_done_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_err_d   = 1'b0;
        gnt_d      = gnt_q;
        seen_low_d = seen_low_q;
        cnt_d      = cnt_q;
        adv        = 1'b0;
        case (state_q)
            INIT_LO: state_d = INIT_HI;
            INIT_HI: begin
                state_d    = IDLE;
                cfg_done_d = 1'b1;
            end
            IDLE: begin
                if (br_cfg != br_cfg_q) begin
                    cfg_done_d = 1'b0;
                    br_cfg_d   = br_cfg;
                    state_d    = INIT_LO;
                end else if (rda) begin
                    state_d = RX_READ;
                end else if ((tx_req != 2'b00) && tbr) begin
                    // latch the grant so the write cycle is immune to req changes
                    gnt_d   = gnt;
                    adv     = 1'b1;
                    state_d = TX_WRITE;
                end
            end
            RX_READ: begin
                rx_data_d  = databus;
                rx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            TX_WRITE: begin
                seen_low_d = 1'b0;
                cnt_d      = 16'h0000;
                state_d    = TX_WAIT;
            end
            TX_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (!tbr) seen_low_d = 1'b1;
                // a completed handshake wins over a timeout in the same cycle
                if (seen_low_q && tbr) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = INIT_LO;
        endcase
    end

    // Outputs: Moore decode, forced to idle while reset is held so an
    // aborted access never shows on the bus
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = IOA_BUF;
        bus_oe = 1'b0;
        bus_do = 8'h00;
        tx_ack = 2'b00;
        if (rst) begin
            case (state_q)
                INIT_LO: begin
                    iocs = 1'b1; iorw = 1'b0; ioaddr = IOA_DBL;
                    bus_oe = 1'b1; bus_do = div[7:0];
                end
                INIT_HI: begin
                    iocs = 1'b1; iorw = 1'b0; ioaddr = IOA_DBH;
                    bus_oe = 1'b1; bus_do = div[15:8];
                end
                RX_READ: begin
                    iocs = 1'b1; iorw = 1'b1; ioaddr = IOA_BUF;
                end
                TX_WRITE: begin
                    iocs = 1'b1; iorw = 1'b0; ioaddr = IOA_BUF;
                    bus_oe = 1'b1;
                    bus_do = gnt_q[1] ? tx_data1 : tx_data0;
                    tx_ack = gnt_q;
                end
                default: ;
            endcase
        end
    end

    assign databus  = bus_oe ? bus_do : 8'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign cfg_done = cfg_done_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spart_bus_ctrl
// Randomized bench with a transaction-level reference model. Stimulus tasks
// push the events the controller must produce (bus writes, received bytes,
// timeouts) into an ordered queue; a negedge monitor pops and compares each
// event the DUT presents. A small SPART model answers reads and toggles tbr.
// ---------------------------------------------------------------------------
module tb_spart_bus_ctrl;

    localparam int unsigned TO = 16;
    localparam int K_WR = 0, K_RX = 1, K_ERR = 2;

    typedef struct {
        int         kind;
        logic [1:0] addr;
        logic [7:0] data;
        logic [1:0] ack;
        logic       cfg;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg, tx_req;
    logic [7:0] tx_data0, tx_data1;
    logic       rda, tbr;
    wire  [7:0] databus;
    logic [1:0] tx_ack, ioaddr;
    logic [7:0] rx_data;
    logic       rx_valid, cfg_done, tx_err, iocs, iorw;

    logic [7:0] rx_byte;
    logic       tbr_stuck;
    int         tbr_lo;
    int         cyc = 0;
    int         last_wr_cyc = 0;
    int         cfg_lo_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;

    // reference model state
    ev_t        exp_q[$];
    int         last_gnt;
    logic [1:0] br_q;

    spart_bus_ctrl #(.CLK_HZ(50_000_000), .TX_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .tx_req(tx_req),
        .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_ack(tx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .cfg_done(cfg_done),
        .tx_err(tx_err), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr)
    );

    // SPART drives the buffer byte during reads
    assign databus = (iocs && iorw) ? rx_byte : 8'bz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] mdiv(input logic [1:0] sel);
        int baud;
        int d;
        baud = 4800 << sel;
        d = 50_000_000 / baud - 1;
        return d[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] addr, input logic [7:0] data,
                        input logic [1:0] ack, input logic cfg);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.ack = ack; e.cfg = cfg;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [1:0] addr, input logic [7:0] data,
                           input logic [1:0] ack, input logic cfg);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %02h ack %b, expected none",
                     kind, addr, data, ack);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data || e.ack != ack || e.cfg != cfg) begin
                miscompares++;
                $display("FAIL event: got kind %0d addr %0d data %02h ack %b cfg %b, expected kind %0d addr %0d data %02h ack %b cfg %b",
                         kind, addr, data, ack, cfg, e.kind, e.addr, e.data, e.ack, e.cfg);
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (!cfg_done) cfg_lo_cnt++;
            if (iocs && !iorw) begin
                observe(K_WR, ioaddr, databus, tx_ack, cfg_done);
                if (ioaddr == 2'b00) last_wr_cyc = cyc;
            end else if (tx_ack != 2'b00) begin
                check("ack_without_write", {30'd0, tx_ack}, 32'd0);
            end
            if (iocs && iorw) check("read_addr", {30'd0, ioaddr}, 32'd0);
            if (rx_valid) observe(K_RX, 2'b00, rx_data, 2'b00, cfg_done);
            if (tx_err) begin
                observe(K_ERR, 2'b00, 8'h00, 2'b00, cfg_done);
                check("err_latency", cyc - last_wr_cyc, TO + 1);
            end
        end
    end

    // SPART and client behaviour: tbr drops for a few cycles after each
    // buffer write, rda clears once the buffer is read, clients drop req on ack
    always @(negedge clk) begin
        if (rst && iocs && !iorw && ioaddr == 2'b00 && !tbr_stuck) begin
            tbr = 1'b0;
            tbr_lo = $urandom_range(2, 6);
        end else if (tbr_lo > 0) begin
            tbr_lo--;
            if (tbr_lo == 0) tbr = 1'b1;
        end
        if (rst && iocs && iorw) rda = 1'b0;
        if (rst && tx_ack[0]) tx_req[0] = 1'b0;
        if (rst && tx_ack[1]) tx_req[1] = 1'b0;
    end

    task automatic settle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_req != 2'b00 || rda || !tbr || tbr_lo != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL settle_timeout: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    // expected writes for a client request pattern, per round-robin rules
    task automatic model_tx(input logic [1:0] req, input logic [7:0] d0, input logic [7:0] d1);
        int first, second;
        if (req == 2'b11) begin
            first  = (last_gnt == 0) ? 1 : 0;
            second = 1 - first;
            push(K_WR, 2'b00, first  ? d1 : d0, first  ? 2'b10 : 2'b01, 1'b1);
            push(K_WR, 2'b00, second ? d1 : d0, second ? 2'b10 : 2'b01, 1'b1);
            last_gnt = second;
        end else if (req != 2'b00) begin
            first = req[1] ? 1 : 0;
            push(K_WR, 2'b00, first ? d1 : d0, first ? 2'b10 : 2'b01, 1'b1);
            last_gnt = first;
        end
    endtask

    task automatic model_init(input logic [1:0] sel);
        logic [15:0] d;
        d = mdiv(sel);
        push(K_WR, 2'b10, d[7:0],  2'b00, 1'b0);
        push(K_WR, 2'b11, d[15:8], 2'b00, 1'b0);
    endtask

    task automatic tx_op(input logic [1:0] req, input logic [7:0] d0, input logic [7:0] d1);
        model_tx(req, d0, d1);
        tx_data0 = d0; tx_data1 = d1; tx_req = req;
        settle();
    endtask

    task automatic rx_op(input logic [7:0] b, input logic [1:0] req,
                         input logic [7:0] d0, input logic [7:0] d1);
        push(K_RX, 2'b00, b, 2'b00, 1'b1);
        model_tx(req, d0, d1);
        rx_byte = b; tx_data0 = d0; tx_data1 = d1;
        rda = 1'b1; tx_req = req;
        settle();
    endtask

    task automatic cfg_op(input logic [1:0] sel);
        int exp_lo;
        exp_lo = 0;
        if (sel != br_q) begin
            model_init(sel);
            br_q = sel;
            exp_lo = 2;
        end
        cfg_lo_cnt = 0;
        br_cfg = sel;
        settle();
        check("cfg_low_cycles", cfg_lo_cnt, exp_lo);
    endtask

    initial begin
        int n;
        rst = 1'b0; br_cfg = 2'b01; tx_req = 2'b00; tx_data0 = 8'h00; tx_data1 = 8'h00;
        rda = 1'b0; tbr = 1'b1; tbr_stuck = 1'b0; tbr_lo = 0; rx_byte = 8'h00;
        last_gnt = 1; br_q = 2'b01;
        #12;
        // reset values
        check("rst_iocs", iocs, 1'b0);
        check("rst_iorw", iorw, 1'b1);
        check("rst_ioaddr", ioaddr, 2'b00);
        check("rst_tx_ack", tx_ack, 2'b00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_tx_err", tx_err, 1'b0);

        // divisor load after reset: 9600 baud -> 0x1457
        model_init(2'b01);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("init1_addr", ioaddr, 2'b10);
        check("init1_data", databus, 8'h57);
        check("init1_cfg", cfg_done, 1'b0);
        @(posedge clk); #1;
        check("init2_addr", ioaddr, 2'b11);
        check("init2_data", databus, 8'h14);
        @(posedge clk); #1;
        check("init3_cfg", cfg_done, 1'b1);
        check("init3_iocs", iocs, 1'b0);
        settle();

        // contention and round-robin
        tx_op(2'b11, 8'hA5, 8'h3C);
        tx_op(2'b11, 8'h11, 8'h22);
        tx_op(2'b10, 8'h77, 8'h88);
        tx_op(2'b11, 8'h01, 8'h02);

        // RX beats TX in the same cycle
        rx_op(8'h5A, 2'b01, 8'hC3, 8'h00);

        // TX_WAIT timeout: tbr never drops
        tbr_stuck = 1'b1;
        push(K_WR, 2'b00, 8'h99, 2'b01, 1'b1);
        push(K_ERR, 2'b00, 8'h00, 2'b00, 1'b1);
        last_gnt = 0;
        tx_data0 = 8'h99; tx_req = 2'b01;
        settle();
        tbr_stuck = 1'b0;

        // br_cfg change during TX_WAIT is deferred to IDLE
        model_tx(2'b01, 8'h42, 8'h00);
        tx_data0 = 8'h42; tx_req = 2'b01;
        n = 0;
        while (tx_req != 2'b00 && n < 50) begin @(negedge clk); n++; end
        #2;
        model_init(2'b11);
        br_q = 2'b11;
        cfg_lo_cnt = 0;
        br_cfg = 2'b11;
        settle();
        check("deferred_cfg_low_cycles", cfg_lo_cnt, 2);

        // request withdrawn before it could be granted: nothing happens
        tbr = 1'b0;
        tx_data0 = 8'hEE; tx_req = 2'b01;
        repeat (3) @(negedge clk);
        #2;
        tx_req = 2'b00; tbr = 1'b1;
        settle();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: tx_op(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
                1: rx_op(8'($urandom), 2'b00, 8'h00, 8'h00);
                2: rx_op(8'($urandom), 2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
                default: cfg_op(2'($urandom));
            endcase
        end

        // reset in the middle of a buffer write
        model_tx(2'b10, 8'h00, 8'h6B);
        tx_data1 = 8'h6B; tx_req = 2'b10;
        n = 0;
        while (tx_ack == 2'b00 && n < 50) begin @(negedge clk); #2; n++; end
        check("mid_rst_reached_write", (tx_ack != 2'b00), 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_iocs", iocs, 1'b0);
        check("mid_rst_iorw", iorw, 1'b1);
        check("mid_rst_tx_ack", tx_ack, 2'b00);
        check("mid_rst_cfg_done", cfg_done, 1'b0);
        tx_req = 2'b00;
        exp_q.delete();
        last_gnt = 1;
        br_q = 2'b01;
        model_init(2'b01);
        if (br_cfg != 2'b01) begin
            model_init(br_cfg);
            br_q = br_cfg;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("restart_addr", ioaddr, 2'b10);
        settle();
        tx_op(2'b11, 8'h5C, 8'hC5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
